// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the pipelined RISC-V core.
//
// Holds the register file, the write-back source mux, the immediate generator,
// operand forwarding (EX > MEM > WB > register file) and load-use hazard
// detection. It also owns the ID/EX pipeline register, which supports hold,
// flush and bubble insertion.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   id_valid_i, inst_i      IF/ID contents
//   pc_i                    PC of inst_i
//   imm_sel_i               immediate format (0 I, 1 S, 2 B, 3 U, 4 J, else 0)
//   uses_rs1_i, uses_rs2_i  operand usage, for hazard detection only
//   wb_*                    write-back port and source candidates
//   ex_we_i .. ex_result_i  EX-stage forwarding and load information
//   mem_we_i .. mem_result_i MEM-stage forwarding information
//   hold_i, flush_i         downstream stall, redirect kill
//   id_stall_o              IF/ID must hold
//   wd_o                    selected write-back data
//   ex_*_o                  registered ID/EX fields
//   dbg_reg_o               raw register-file read of DBG_REG
module id_stage #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int DBG_REG = 19,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            id_valid_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [2:0]      imm_sel_i,
  input  logic            uses_rs1_i,
  input  logic            uses_rs2_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_rd_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic [XLEN-1:0] wb_alu_i,
  input  logic [XLEN-1:0] wb_mem_i,
  input  logic            ex_we_i,
  input  logic            ex_is_load_i,
  input  logic [AW-1:0]   ex_rd_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            mem_we_i,
  input  logic [AW-1:0]   mem_rd_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic            id_stall_o,
  output logic [XLEN-1:0] wd_o,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_o,
  output logic [XLEN-1:0] ex_rs2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [AW-1:0]   ex_rd_o,
  output logic [XLEN-1:0] dbg_reg_o
);

  localparam logic [AW-1:0] DBG_IDX = AW'(DBG_REG % NREG);

  logic [XLEN-1:0] rf_q [NREG];

  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_val;
  logic            load_use;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q, ex_rs1_q, ex_rs2_q, ex_imm_q;
  logic [AW-1:0]   ex_rd_q;

  // Opcode bits are decoded elsewhere; only the register and immediate fields matter here.
  logic unused_opcode;
  assign unused_opcode = ^inst_i[6:0];

  assign rs1 = inst_i[15 +: AW];
  assign rs2 = inst_i[20 +: AW];
  assign rd  = inst_i[7 +: AW];

  always_comb begin
    wd = '0;
    case (wb_sel_i)
      2'd0:    wd = wb_pc_i;
      2'd1:    wd = wb_alu_i;
      2'd2:    wd = wb_mem_i;
      default: wd = '0;
    endcase
  end

  assign wd_o = wd;

  // Loads in EX have no data yet, so they are skipped here and caught as load-use instead.
  function automatic logic [XLEN-1:0] resolve(input logic [AW-1:0] rs);
    if (rs == '0) begin
      return '0;
    end else if (ex_we_i && !ex_is_load_i && ex_rd_i == rs) begin
      return ex_result_i;
    end else if (mem_we_i && mem_rd_i == rs) begin
      return mem_result_i;
    end else if (wb_we_i && wb_rd_i == rs) begin
      return wd;
    end else begin
      return rf_q[rs];
    end
  endfunction

  always_comb begin
    rs1_val = resolve(rs1);
    rs2_val = resolve(rs2);
  end

  always_comb begin
    imm32 = '0;
    case (imm_sel_i)
      3'd0:    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      3'd1:    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      3'd2:    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      3'd3:    imm32 = {inst_i[31:12], 12'h000};
      3'd4:    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every format, U included, is sign-extended from bit 31 for XLEN=64.
  assign imm_val = XLEN'($signed(imm32));

  assign load_use = id_valid_i && ex_we_i && ex_is_load_i && (ex_rd_i != '0) &&
                    ((uses_rs1_i && rs1 == ex_rd_i) || (uses_rs2_i && rs2 == ex_rd_i));

  assign id_stall_o = load_use | hold_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we_i && wb_rd_i != '0) begin
      rf_q[wb_rd_i] <= wd;
    end
  end

  assign dbg_reg_o = rf_q[DBG_IDX];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
    end else if (flush_i) begin
      ex_valid_q <= 1'b0;
    end else if (hold_i) begin
      ex_valid_q <= ex_valid_q;
    end else if (load_use) begin
      ex_valid_q <= 1'b0;
    end else begin
      ex_valid_q <= id_valid_i;
      ex_pc_q    <= pc_i;
      ex_rs1_q   <= rs1_val;
      ex_rs2_q   <= rs2_val;
      ex_imm_q   <= imm_val;
      ex_rd_q    <= rd;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign ex_pc_o    = ex_pc_q;
  assign ex_rs1_o   = ex_rs1_q;
  assign ex_rs2_o   = ex_rs2_q;
  assign ex_imm_o   = ex_imm_q;
  assign ex_rd_o    = ex_rd_q;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

  typedef struct {
    bit        id_valid;
    bit [31:0] inst;
    bit [31:0] pc;
    bit [2:0]  imm_sel;
    bit        uses_rs1, uses_rs2;
    bit        wb_we;
    bit [4:0]  wb_rd;
    bit [1:0]  wb_sel;
    bit [31:0] wb_pc, wb_alu, wb_mem;
    bit        ex_we, ex_is_load;
    bit [4:0]  ex_rd;
    bit [31:0] ex_result;
    bit        mem_we;
    bit [4:0]  mem_rd;
    bit [31:0] mem_result;
    bit        hold, flush;
  } stim_t;

  typedef struct {
    bit        stall;
    bit [31:0] wd, dbg;
    bit        v;
    bit [31:0] pc, rs1, rs2, imm;
    bit [4:0]  rd;
    bit        v64;
    bit [63:0] imm64, pc64;
    bit [3:0]  rd64;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid;
  logic [31:0] inst, pc;
  logic [2:0]  imm_sel;
  logic        uses_rs1, uses_rs2;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [31:0] wb_pc, wb_alu, wb_mem;
  logic        ex_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        hold, flush;

  logic        id_stall;
  logic [31:0] wd_o, dbg;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [4:0]  ex_rd_o;

  logic [63:0] pc64;
  logic        stall64, valid64;
  logic [63:0] wd64, epc64, rs1_64, rs2_64, imm64, dbg64;
  logic [3:0]  rd64;

  assign pc64 = {32'h0, pc};

  always #5 clk = ~clk;

  id_stage dut (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .inst_i(inst), .pc_i(pc),
    .imm_sel_i(imm_sel), .uses_rs1_i(uses_rs1), .uses_rs2_i(uses_rs2),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_sel_i(wb_sel), .wb_pc_i(wb_pc),
    .wb_alu_i(wb_alu), .wb_mem_i(wb_mem), .ex_we_i(ex_we), .ex_is_load_i(ex_is_load),
    .ex_rd_i(ex_rd), .ex_result_i(ex_result), .mem_we_i(mem_we), .mem_rd_i(mem_rd),
    .mem_result_i(mem_result), .hold_i(hold), .flush_i(flush), .id_stall_o(id_stall),
    .wd_o(wd_o), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs1_o(ex_rs1),
    .ex_rs2_o(ex_rs2), .ex_imm_o(ex_imm), .ex_rd_o(ex_rd_o), .dbg_reg_o(dbg)
  );

  // Second configuration: only the immediate/PC path is exercised, everything else idle.
  id_stage #(.XLEN(64), .NREG(16), .DBG_REG(19)) dut64 (
    .clk_i(clk), .reset_i(reset), .id_valid_i(1'b1), .inst_i(inst), .pc_i(pc64),
    .imm_sel_i(imm_sel), .uses_rs1_i(1'b0), .uses_rs2_i(1'b0),
    .wb_we_i(1'b0), .wb_rd_i(4'd0), .wb_sel_i(2'd0), .wb_pc_i(64'd0),
    .wb_alu_i(64'd0), .wb_mem_i(64'd0), .ex_we_i(1'b0), .ex_is_load_i(1'b0),
    .ex_rd_i(4'd0), .ex_result_i(64'd0), .mem_we_i(1'b0), .mem_rd_i(4'd0),
    .mem_result_i(64'd0), .hold_i(1'b0), .flush_i(1'b0), .id_stall_o(stall64),
    .wd_o(wd64), .ex_valid_o(valid64), .ex_pc_o(epc64), .ex_rs1_o(rs1_64),
    .ex_rs2_o(rs2_64), .ex_imm_o(imm64), .ex_rd_o(rd64), .dbg_reg_o(dbg64)
  );

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  // Reference state: what the DUT registers will hold after the next rising edge.
  bit [31:0] m_rf [32];
  bit        m_valid;
  bit [31:0] m_pc, m_rs1, m_rs2, m_imm;
  bit [4:0]  m_rd;
  bit        m_v64;
  bit [63:0] m_imm64, m_pc64;
  bit [3:0]  m_rd64;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    foreach (m_rf[i]) m_rf[i] = '0;
    m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_rd = 0;
    m_v64 = 1; m_imm64 = 0; m_pc64 = 0; m_rd64 = 0;
  endfunction

  // Immediate value computed arithmetically from the RISC-V field definitions.
  function automatic longint model_imm(input bit [31:0] i, input bit [2:0] sel);
    longint v;
    case (sel)
      3'd0: begin
        v = longint'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      3'd1: begin
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      3'd2: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 +
            longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd3: begin
        v = longint'(i[31:12]) * 4096;
        if (v >= (longint'(1) << 31)) v -= (longint'(1) << 32);
      end
      3'd4: begin
        v = longint'(i[31]) * (longint'(1) << 20) + longint'(i[19:12]) * 4096 +
            longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic bit [31:0] m_operand(input stim_t s, input bit [4:0] rs,
                                          input bit [31:0] wdv);
    if (rs == 0) return 0;
    if (s.ex_we && !s.ex_is_load && s.ex_rd == rs) return s.ex_result;
    if (s.mem_we && s.mem_rd == rs) return s.mem_result;
    if (s.wb_we && s.wb_rd == rs) return wdv;
    return m_rf[rs];
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t add_op(input bit [4:0] rd, input bit [4:0] r1, input bit [4:0] r2);
    stim_t s;
    s = nop();
    s.id_valid = 1;
    s.inst = {7'h00, r2, r1, 3'h0, rd, 7'h33};
    s.uses_rs1 = 1;
    s.uses_rs2 = 1;
    return s;
  endfunction

  function automatic bit [4:0] rnd_reg();
    int k;
    k = $urandom_range(0, 9);
    if (k == 8) return 5'd19;
    if (k == 9) return 5'd31;
    return 5'(k);
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.id_valid   = $urandom_range(0, 4) != 0;
    s.inst       = $urandom;
    s.inst[19:15] = rnd_reg();
    s.inst[24:20] = rnd_reg();
    s.inst[11:7]  = rnd_reg();
    s.pc         = $urandom;
    s.imm_sel    = 3'($urandom_range(0, 7));
    s.uses_rs1   = $urandom_range(0, 1) != 0;
    s.uses_rs2   = $urandom_range(0, 1) != 0;
    s.wb_we      = $urandom_range(0, 2) != 0;
    s.wb_rd      = rnd_reg();
    s.wb_sel     = 2'($urandom_range(0, 3));
    s.wb_pc      = $urandom;
    s.wb_alu     = $urandom;
    s.wb_mem     = $urandom;
    s.ex_we      = $urandom_range(0, 1) != 0;
    s.ex_is_load = $urandom_range(0, 2) == 0;
    s.ex_rd      = rnd_reg();
    s.ex_result  = $urandom;
    s.mem_we     = $urandom_range(0, 1) != 0;
    s.mem_rd     = rnd_reg();
    s.mem_result = $urandom;
    s.hold       = $urandom_range(0, 5) == 0;
    s.flush      = $urandom_range(0, 7) == 0;
    return s;
  endfunction

  // Applies one cycle of stimulus after the rising edge and queues the expectation
  // for the monitor, then advances the reference state across the next edge.
  task automatic drive(input stim_t s);
    exp_t e;
    bit [4:0] r1i, r2i;
    bit [31:0] wdv, o1, o2;
    bit lu;
    longint iv;
    @(posedge clk);
    #1;
    id_valid = s.id_valid; inst = s.inst; pc = s.pc; imm_sel = s.imm_sel;
    uses_rs1 = s.uses_rs1; uses_rs2 = s.uses_rs2;
    wb_we = s.wb_we; wb_rd = s.wb_rd; wb_sel = s.wb_sel;
    wb_pc = s.wb_pc; wb_alu = s.wb_alu; wb_mem = s.wb_mem;
    ex_we = s.ex_we; ex_is_load = s.ex_is_load; ex_rd = s.ex_rd; ex_result = s.ex_result;
    mem_we = s.mem_we; mem_rd = s.mem_rd; mem_result = s.mem_result;
    hold = s.hold; flush = s.flush;

    r1i = s.inst[19:15];
    r2i = s.inst[24:20];
    case (s.wb_sel)
      2'd0: wdv = s.wb_pc;
      2'd1: wdv = s.wb_alu;
      2'd2: wdv = s.wb_mem;
      default: wdv = 0;
    endcase
    lu = s.id_valid && s.ex_we && s.ex_is_load && s.ex_rd != 0 &&
         ((s.uses_rs1 && r1i == s.ex_rd) || (s.uses_rs2 && r2i == s.ex_rd));

    e.stall = lu || s.hold; e.wd = wdv; e.dbg = m_rf[19];
    e.v = m_valid; e.pc = m_pc; e.rs1 = m_rs1; e.rs2 = m_rs2; e.imm = m_imm; e.rd = m_rd;
    e.v64 = m_v64; e.imm64 = m_imm64; e.pc64 = m_pc64; e.rd64 = m_rd64;
    sb_q.push_back(e);

    o1 = m_operand(s, r1i, wdv);
    o2 = m_operand(s, r2i, wdv);
    iv = model_imm(s.inst, s.imm_sel);
    if (s.flush) begin
      m_valid = 0;
    end else if (!s.hold) begin
      if (lu) begin
        m_valid = 0;
      end else begin
        m_valid = s.id_valid; m_pc = s.pc; m_rs1 = o1; m_rs2 = o2;
        m_imm = iv[31:0]; m_rd = s.inst[11:7];
      end
    end
    if (s.wb_we && s.wb_rd != 0) m_rf[s.wb_rd] = wdv;
    m_v64 = 1; m_imm64 = iv; m_pc64 = {32'h0, s.pc}; m_rd64 = s.inst[10:7];
  endtask

  // Asserts reset between edges and checks that it acts without waiting for a clock.
  task automatic mid_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    cmp("rst_valid_async", ex_valid, 0);
    cmp("rst_dbg_async", dbg, 0);
    cmp("rst_pc_async", ex_pc, 0);
    model_clear();
    #1 reset = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle and compares all observed outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp("id_stall", id_stall, e.stall);
        cmp("wd", wd_o, e.wd);
        cmp("dbg_reg", dbg, e.dbg);
        cmp("ex_valid", ex_valid, e.v);
        cmp("ex_pc", ex_pc, e.pc);
        cmp("ex_rs1", ex_rs1, e.rs1);
        cmp("ex_rs2", ex_rs2, e.rs2);
        cmp("ex_imm", ex_imm, e.imm);
        cmp("ex_rd", ex_rd_o, e.rd);
        cmp("ex_valid64", valid64, e.v64);
        cmp("ex_imm64", imm64, e.imm64);
        cmp("ex_pc64", epc64, e.pc64);
        cmp("ex_rd64", rd64, e.rd64);
        cmp("idle64", {stall64, rs1_64 | rs2_64 | wd64 | dbg64}, 0);
      end
    end
  end

  initial begin
    stim_t s;
    model_clear();
    {id_valid, inst, pc, imm_sel, uses_rs1, uses_rs2, wb_we, wb_rd, wb_sel} = '0;
    {wb_pc, wb_alu, wb_mem, ex_we, ex_is_load, ex_rd, ex_result} = '0;
    {mem_we, mem_rd, mem_result, hold, flush} = '0;
    #12 reset = 1'b0;

    // Reset clears register file and ID/EX asynchronously.
    s = nop(); s.wb_we = 1; s.wb_rd = 5; s.wb_sel = 1; s.wb_alu = 32'h1234;
    drive(s);
    s = add_op(1, 5, 0); s.wb_we = 1; s.wb_rd = 19; s.wb_sel = 2; s.wb_mem = 32'hCAFE;
    drive(s);
    drive(nop());
    #1;
    cmp("pre_rst_x5", ex_rs1, 32'h1234);
    cmp("pre_rst_dbg", dbg, 32'hCAFE);
    mid_reset();
    drive(add_op(2, 5, 0));
    drive(nop());
    #1 cmp("x5_after_rst", ex_rs1, 0);

    // Same-cycle write-through.
    s = add_op(1, 3, 0); s.wb_we = 1; s.wb_rd = 3; s.wb_sel = 1; s.wb_alu = 32'hA5A5A5A5;
    drive(s);
    drive(nop());
    #1 cmp("write_through", ex_rs1, 32'hA5A5A5A5);

    // Forwarding priority EX > MEM > WB.
    s = add_op(1, 7, 0);
    s.ex_we = 1; s.ex_rd = 7; s.ex_result = 1;
    s.mem_we = 1; s.mem_rd = 7; s.mem_result = 2;
    s.wb_we = 1; s.wb_rd = 7; s.wb_sel = 1; s.wb_alu = 3;
    drive(s);
    s.ex_we = 0;
    drive(s);
    #1 cmp("prio_ex", ex_rs1, 1);
    s.mem_we = 0;
    drive(s);
    #1 cmp("prio_mem", ex_rs1, 2);
    drive(nop());
    #1 cmp("prio_wb", ex_rs1, 3);

    // Load-use: one bubble, then MEM forwarding.
    s = add_op(1, 0, 8); s.uses_rs1 = 0; s.ex_we = 1; s.ex_is_load = 1; s.ex_rd = 8;
    drive(s);
    #1 cmp("lu_stall", id_stall, 1);
    s.ex_we = 0; s.ex_is_load = 0; s.mem_we = 1; s.mem_rd = 8; s.mem_result = 32'hDEAD;
    drive(s);
    #1;
    cmp("lu_bubble", ex_valid, 0);
    cmp("lu_stall_clear", id_stall, 0);
    drive(nop());
    #1;
    cmp("lu_valid", ex_valid, 1);
    cmp("lu_rs2", ex_rs2, 32'hDEAD);

    // Immediates, both widths.
    s = nop(); s.id_valid = 1; s.inst = 32'hFE000EE3; s.imm_sel = 2;
    drive(s);
    drive(nop());
    #1;
    cmp("imm_b", ex_imm, 32'hFFFFFFFC);
    cmp("imm_b64", imm64, 64'hFFFFFFFFFFFFFFFC);
    s.inst = 32'h0000006F; s.imm_sel = 4;
    drive(s);
    drive(nop());
    #1 cmp("imm_j", ex_imm, 0);
    s.inst = 32'h800000B7; s.imm_sel = 3;
    drive(s);
    drive(nop());
    #1;
    cmp("imm_u", ex_imm, 32'h80000000);
    cmp("imm_u64", imm64, 64'hFFFFFFFF80000000);

    // x0 is never written.
    s = nop(); s.wb_we = 1; s.wb_rd = 0; s.wb_sel = 1; s.wb_alu = 32'hFFFF;
    drive(s);
    drive(add_op(1, 0, 0));
    drive(nop());
    #1 cmp("x0_read", ex_rs1, 0);

    // Hold for three cycles.
    s = add_op(4, 0, 0); s.pc = 32'h100;
    drive(s);
    s = add_op(5, 0, 0); s.pc = 32'h200; s.hold = 1;
    for (int k = 0; k < 3; k++) begin
      drive(s);
      #1 cmp("hold_pc", ex_pc, (k == 0) ? 32'h100 : 32'h100);
    end
    drive(nop());
    #1;
    cmp("hold_pc_end", ex_pc, 32'h100);
    cmp("hold_valid", ex_valid, 1);

    // Flush beats hold.
    drive(add_op(4, 0, 0));
    s = add_op(5, 0, 0); s.hold = 1; s.flush = 1;
    drive(s);
    #1 cmp("fh_stall", id_stall, 1);
    drive(nop());
    #1 cmp("fh_valid", ex_valid, 0);

    // Flush with load-use still stalls.
    drive(add_op(4, 0, 0));
    s = add_op(1, 9, 0); s.uses_rs2 = 0; s.ex_we = 1; s.ex_is_load = 1; s.ex_rd = 9;
    s.flush = 1;
    drive(s);
    #1 cmp("flu_stall", id_stall, 1);
    drive(nop());
    #1 cmp("flu_valid", ex_valid, 0);

    // Randomized traffic with one mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        drive(nop());
        mid_reset();
      end
      drive(rnd_stim());
    end
    drive(nop());
    repeat (2) @(negedge clk);
    #1 cmp("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Parametrised instruction-decode stage for the pipelined RISC-V core. It contains the register file, the write-back source mux, the immediate generator and an internal forwarding unit with EX > MEM > WB priority. It also detects load-use hazards and owns the ID/EX pipeline register, including hold, flush and bubble insertion. It sits between the IF/ID register and the execute stage and is the successor to the combinational decoder with externally supplied forwarding selects.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- NREG, 32, number of architectural registers; legal values are 16 (RV32E) and 32. AW = $clog2(NREG).
- DBG_REG, 19, register index driven on dbg_reg_o.
- clk_i  in  1  single clock; all state updates on the rising edge.
- reset_i  in  1  reset, asynchronous, active-high.
- id_valid_i  in  1  IF/ID holds a valid instruction.
- inst_i  in  32  instruction word. rs1 = inst_i[15+:AW], rs2 = inst_i[20+:AW], rd = inst_i[7+:AW].
- pc_i  in  XLEN  PC of inst_i.
- imm_sel_i  in  3  immediate format: 0 I, 1 S, 2 B, 3 U, 4 J, others give zero.
- uses_rs1_i, uses_rs2_i  in  1 each  instruction reads rs1 / rs2 (used for hazard detection only).
- wb_we_i  in  1  write-back enable.
- wb_rd_i  in  AW  write-back destination register.
- wb_sel_i  in  2  write-back source: 0 return PC, 1 ALU result, 2 memory data, 3 zero.
- wb_pc_i, wb_alu_i, wb_mem_i  in  XLEN each  write-back candidate values.
- ex_we_i  in  1  EX-stage instruction writes a register.
- ex_is_load_i  in  1  EX-stage instruction is a load.
- ex_rd_i  in  AW  EX-stage destination.
- ex_result_i  in  XLEN  EX-stage ALU result.
- mem_we_i  in  1  MEM-stage instruction writes a register.
- mem_rd_i  in  AW  MEM-stage destination.
- mem_result_i  in  XLEN  MEM-stage result value.
- hold_i  in  1  downstream stall; freeze the ID/EX register.
- flush_i  in  1  branch/jump redirect; kill the ID/EX contents.
- id_stall_o  out  1  combinational; IF/ID must hold when this is high.
- wd_o  out  XLEN  combinational selected write-back data.
- ex_valid_o  out  1  registered; ID/EX holds a valid instruction.
- ex_pc_o, ex_rs1_o, ex_rs2_o, ex_imm_o  out  XLEN each  registered ID/EX fields.
- ex_rd_o  out  AW  registered destination register.
- dbg_reg_o  out  XLEN  combinational raw register-file read of DBG_REG (no forwarding applied).

## Operation
- **Write-back data.** wd_o = mux(wb_sel_i) of wb_pc_i, wb_alu_i, wb_mem_i; selector value 3 gives 0.
- **Register file.** On a clock edge with wb_we_i=1 and wb_rd_i≠0, the entry at wb_rd_i is written with wd_o. Register x0 always reads 0 and is never written. Writes occur regardless of hold_i, flush_i and stalls.
- **Operand resolution (per operand, first match wins):**
  - rs = 0 → 0.
  - ex_we_i & ~ex_is_load_i & ex_rd_i = rs → ex_result_i.
  - mem_we_i & mem_rd_i = rs → mem_result_i.
  - wb_we_i & wb_rd_i = rs → wd_o (same-cycle write-through).
  - otherwise → register file contents.
- **Immediate generation.** Immediates follow the RV32 encodings and are sign-extended to XLEN; U-type is inst[31:12]<<12, sign-extended when XLEN=64.
- **Load-use hazard.** load_use = id_valid_i & ex_we_i & ex_is_load_i & ex_rd_i≠0 & ((uses_rs1_i & rs1=ex_rd_i) | (uses_rs2_i & rs2=ex_rd_i)).
- **Stall output.** id_stall_o = load_use | hold_i.
- **ID/EX update (priority order):**
  1. flush_i → ex_valid_o=0; other fields unchanged.
  2. hold_i → all fields unchanged.
  3. load_use → ex_valid_o=0 (bubble); other fields unchanged.
  4. otherwise → capture pc, resolved rs1/rs2, imm and rd; ex_valid_o=id_valid_i.

## Timing
- Reset (asynchronous, any time including mid-stall): all registers, ex_valid_o and every ex_*_o output go to 0. All register-file entries clear to 0. Combinational outputs follow their inputs immediately.
- Decode latency is 1 cycle: an instruction present at edge N appears on ex_*_o after edge N.
- Load-use costs exactly 1 bubble. On the next cycle the load has left EX and the value is forwarded from MEM.
- Simultaneous flush_i and hold_i: flush wins.
- Simultaneous flush_i and load_use: ex_valid_o=0, and id_stall_o is still driven high.
- A WB write to the register being read in the same cycle: ex_rs*_o captures the new value.

## Test plan
- Reset: write x5=0x1234 via WB, assert reset_i between edges → ex_valid_o=0 and dbg_reg_o=0 at once; a later read of x5 returns 0.
- Write-through: WB writes x3=0xA5A5A5A5 while ID decodes `add x1,x3,x0` → ex_rs1_o=0xA5A5A5A5 after the edge.
- Priority: EX, MEM and WB all target x7 with 1, 2 and 3 respectively → ex_rs1_o=1. With EX invalid → 2. With EX and MEM invalid → 3.
- Load-use: EX is `lw x8`, ID uses rs2=x8 → id_stall_o=1 and ex_valid_o=0 for one cycle. Next cycle, with MEM forwarding 0xDEAD, ex_rs2_o=0xDEAD.
- Immediates: B-type 0xFE000EE3 → ex_imm_o=0xFFFFFFFC. J-type 0x0000006F → 0. x0 destination write of 0xFFFF leaves x0 reading 0.
- Control: hold_i for 3 cycles keeps ex_*_o constant. flush_i together with hold_i → ex_valid_o=0 next cycle. Repeat the run with NREG=16, XLEN=64 and check sign extension to 64 bits.
